// File: rtl/counter_8b.sv
// Loadable up/down counter with count enable; reset beats load, load beats count.
// Every input takes effect on dataout one clk edge after it is sampled; there is no backpressure.
module counter_8b #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             updwn,
  input  logic             en,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  logic [WIDTH-1:0] cnt;

  // Wrap-around in both directions comes from the natural WIDTH-bit truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RESET_VAL;
    end else if (ld_en) begin
      cnt <= datain;
    end else if (en) begin
      if (updwn) begin
        cnt <= cnt + WIDTH'(1);
      end else begin
        cnt <= cnt - WIDTH'(1);
      end
    end
  end

  assign dataout = cnt;

endmodule

// File: tb/tb_counter_8b.sv
// Bench for counter_8b: directed scenarios plus random stimulus, all checked against
// an arithmetic reference model of the counter value.
module tb_counter_8b;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_en;
  logic       updwn;
  logic       en;
  logic [7:0] datain;
  logic [7:0] dataout;

  int total = 0;
  int bad   = 0;
  int model = 0;

  counter_8b #(
    .WIDTH    (8),
    .RESET_VAL(8'd0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ld_en  (ld_en),
    .updwn  (updwn),
    .en     (en),
    .datain (datain),
    .dataout(dataout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: dataout=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, advance the reference, then compare after the edge.
  // When exp >= 0 the result is also compared against a hand-derived constant.
  task automatic step(input logic r, input logic l, input logic u, input logic e,
                      input logic [7:0] d, input string tag, input int exp = -1);
    @(negedge clk);
    rst = r; ld_en = l; updwn = u; en = e; datain = d;
    if (r)      model = 0;
    else if (l) model = int'(d);
    else if (e) model = u ? (model + 1) % 256 : (model + 255) % 256;
    @(posedge clk);
    #1;
    check(tag, dataout, 8'(model));
    if (exp >= 0) check({tag, "_const"}, dataout, 8'(exp));
  endtask

  initial begin
    rst = 1'b0; ld_en = 1'b0; updwn = 1'b0; en = 1'b0; datain = 8'd0;

    step(1, 0, 0, 0, 8'd0, "reset", 0);

    // Load with en/updwn also active, then hold while ld_en stays high.
    step(0, 1, 1, 1, 8'd255, "load", 255);
    step(0, 1, 1, 1, 8'd255, "load_hold", 255);

    step(1, 1, 1, 1, 8'd255, "rst_beats_load", 0);

    for (int i = 1; i <= 5; i++) step(0, 0, 1, 1, 8'd0, "up", i);

    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'd99, "hold", 5);

    step(0, 1, 0, 1, 8'd63, "load_beats_down", 63);
    for (int i = 1; i <= 10; i++) step(0, 0, 1, 1, 8'd0, "up_from_63", 63 + i);

    step(0, 1, 0, 0, 8'd255, "load255", 255);
    step(0, 0, 1, 1, 8'd0, "wrap_up", 0);
    step(0, 1, 0, 0, 8'd0, "load0", 0);
    step(0, 0, 0, 1, 8'd0, "wrap_down", 255);

    step(0, 1, 0, 0, 8'd10, "load10", 10);
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1, 8'd0, "down", 10 - i);
    step(0, 0, 1, 1, 8'd0, "flip_up", 8);

    // Counting resumes from zero straight after a mid-count reset.
    step(1, 0, 1, 1, 8'd0, "rst_mid_count", 0);
    step(0, 0, 0, 1, 8'd0, "resume_down", 255);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
